// File: rtl/ddr3_rdback_collector.sv
// ddr3_rdback_collector
// Pairs each DDR3 PHY read burst with the maintenance flag recorded when the
// matching READ was issued, in issue order. Maintenance bursts are dropped and
// user bursts go into a first-word-fall-through output FIFO. Protocol problems
// are reported through sticky error flags.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   rd_issue/_maint        READ issued this cycle and its maintenance flag
//   phy_rd_valid/_data     one 512-bit burst from the PHY
//   rdback_valid/_data     head of the output FIFO (valid/ready toward the DMA)
//   rdback_ready           consumer accepts the head
//   outstanding            read tags currently held
//   delivered_cnt          user bursts written into the output FIFO (wraps)
//   err_tag_ovf            issue lost because the tag FIFO was full
//   err_unexp              burst arrived with no outstanding read
//   err_out_ovf            user burst dropped because the output FIFO was full
//   err_timeout            oldest read waited more than TIMEOUT cycles
//   clr_err                synchronous clear of the sticky errors
module ddr3_rdback_collector #(
    parameter int unsigned TAG_DEPTH = 16,
    parameter int unsigned OUT_DEPTH = 8,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_issue,
    input  logic                         rd_issue_maint,
    input  logic                         phy_rd_valid,
    input  logic [511:0]                 phy_rd_data,
    output logic                         rdback_valid,
    output logic [511:0]                 rdback_data,
    input  logic                         rdback_ready,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic [31:0]                  delivered_cnt,
    output logic                         err_tag_ovf,
    output logic                         err_unexp,
    output logic                         err_out_ovf,
    output logic                         err_timeout,
    input  logic                         clr_err
);

    localparam int unsigned DATA_W = 512;
    localparam int unsigned TAG_AW = $clog2(TAG_DEPTH);
    localparam int unsigned TAG_CW = TAG_AW + 1;
    localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
    localparam int unsigned OUT_CW = OUT_AW + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT + 1);

    // State
    logic [TAG_DEPTH-1:0]  tag_mem_q;
    logic [TAG_AW-1:0]     tag_wr_ptr_q, tag_wr_ptr_d;
    logic [TAG_AW-1:0]     tag_rd_ptr_q, tag_rd_ptr_d;
    logic [TAG_CW-1:0]     tag_cnt_q, tag_cnt_d;
    logic [DATA_W-1:0]     out_mem [OUT_DEPTH];
    logic [OUT_AW-1:0]     out_wr_ptr_q, out_wr_ptr_d;
    logic [OUT_AW-1:0]     out_rd_ptr_q, out_rd_ptr_d;
    logic [OUT_CW-1:0]     out_cnt_q, out_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic [31:0]           deliv_q, deliv_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  e_tag_q, e_tag_d;
    logic                  e_unexp_q, e_unexp_d;
    logic                  e_oovf_q, e_oovf_d;
    logic                  e_to_q, e_to_d;

    // Per-cycle decisions
    logic tag_empty, tag_full, tag_pop, tag_push, tag_head;
    logic out_pop, user_burst, out_push;

    // Next-state logic
    always_comb begin
        tag_empty    = (tag_cnt_q == '0);
        tag_full     = (tag_cnt_q == TAG_CW'(TAG_DEPTH));
        tag_pop      = phy_rd_valid && !tag_empty;
        // A pop in the same cycle frees the slot for a push into a full FIFO.
        tag_push     = rd_issue && (!tag_full || tag_pop);
        tag_head     = tag_mem_q[tag_rd_ptr_q];

        out_pop      = out_valid_q && rdback_ready;
        user_burst   = tag_pop && !tag_head;
        out_push     = user_burst && ((out_cnt_q != OUT_CW'(OUT_DEPTH)) || out_pop);

        tag_wr_ptr_d = tag_wr_ptr_q + TAG_AW'(tag_push);
        tag_rd_ptr_d = tag_rd_ptr_q + TAG_AW'(tag_pop);
        tag_cnt_d    = tag_cnt_q + TAG_CW'(tag_push) - TAG_CW'(tag_pop);

        out_wr_ptr_d = out_wr_ptr_q + OUT_AW'(out_push);
        out_rd_ptr_d = out_rd_ptr_q + OUT_AW'(out_pop);
        out_cnt_d    = out_cnt_q + OUT_CW'(out_push) - OUT_CW'(out_pop);
        out_valid_d  = (out_cnt_d != '0);

        // Registered head: the new head is either this cycle's write (FIFO
        // effectively empty) or an entry already in storage.
        out_data_d   = out_data_q;
        if (out_cnt_d != '0) begin
            if (out_push && (out_cnt_d == OUT_CW'(1))) begin
                out_data_d = phy_rd_data;
            end else begin
                out_data_d = out_mem[out_rd_ptr_d];
            end
        end

        deliv_d      = deliv_q + 32'(out_push);

        // Age of the oldest outstanding tag, saturating one past the limit.
        wait_d       = wait_q;
        if (tag_pop || tag_empty) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
        end

        // Set conditions take priority over clr_err.
        e_tag_d      = (rd_issue && tag_full && !tag_pop) || (e_tag_q   && !clr_err);
        e_unexp_d    = (phy_rd_valid && tag_empty)        || (e_unexp_q && !clr_err);
        e_oovf_d     = (user_burst && !out_push)          || (e_oovf_q  && !clr_err);
        e_to_d       = (wait_d == WAIT_MAX)               || (e_to_q    && !clr_err);
    end

    // Control and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_mem_q    <= '0;
            tag_wr_ptr_q <= '0;
            tag_rd_ptr_q <= '0;
            tag_cnt_q    <= '0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            deliv_q      <= '0;
            wait_q       <= '0;
            e_tag_q      <= 1'b0;
            e_unexp_q    <= 1'b0;
            e_oovf_q     <= 1'b0;
            e_to_q       <= 1'b0;
        end else begin
            if (tag_push) begin
                tag_mem_q[tag_wr_ptr_q] <= rd_issue_maint;
            end
            tag_wr_ptr_q <= tag_wr_ptr_d;
            tag_rd_ptr_q <= tag_rd_ptr_d;
            tag_cnt_q    <= tag_cnt_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_cnt_q    <= out_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            deliv_q      <= deliv_d;
            wait_q       <= wait_d;
            e_tag_q      <= e_tag_d;
            e_unexp_q    <= e_unexp_d;
            e_oovf_q     <= e_oovf_d;
            e_to_q       <= e_to_d;
        end
    end

    // Output data storage; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (out_push) begin
            out_mem[out_wr_ptr_q] <= phy_rd_data;
        end
    end

    assign rdback_valid  = out_valid_q;
    assign rdback_data   = out_data_q;
    assign outstanding   = tag_cnt_q;
    assign delivered_cnt = deliv_q;
    assign err_tag_ovf   = e_tag_q;
    assign err_unexp     = e_unexp_q;
    assign err_out_ovf   = e_oovf_q;
    assign err_timeout   = e_to_q;

endmodule

// File: tb/tb_ddr3_rdback_collector.sv
// Self-checking bench for ddr3_rdback_collector: a behavioural model tracks
// tags, output occupancy and errors; expected user bursts are queued when
// driven and compared against the FIFO head whenever rdback_valid is high.
module tb_ddr3_rdback_collector;

    localparam int unsigned TAG_DEPTH = 16;
    localparam int unsigned OUT_DEPTH = 8;
    localparam int unsigned TIMEOUT   = 1023;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_issue, rd_issue_maint, phy_rd_valid, rdback_ready, clr_err;
    logic [511:0] phy_rd_data;
    logic         rdback_valid;
    logic [511:0] rdback_data;
    logic [4:0]   outstanding;
    logic [31:0]  delivered_cnt;
    logic         err_tag_ovf, err_unexp, err_out_ovf, err_timeout;

    always #5 clk = ~clk;

    ddr3_rdback_collector #(
        .TAG_DEPTH (TAG_DEPTH),
        .OUT_DEPTH (OUT_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_issue       (rd_issue),
        .rd_issue_maint (rd_issue_maint),
        .phy_rd_valid   (phy_rd_valid),
        .phy_rd_data    (phy_rd_data),
        .rdback_valid   (rdback_valid),
        .rdback_data    (rdback_data),
        .rdback_ready   (rdback_ready),
        .outstanding    (outstanding),
        .delivered_cnt  (delivered_cnt),
        .err_tag_ovf    (err_tag_ovf),
        .err_unexp      (err_unexp),
        .err_out_ovf    (err_out_ovf),
        .err_timeout    (err_timeout),
        .clr_err        (clr_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit           m_tag[$];
    logic [511:0] exp_q[$];
    int           m_out_cnt;
    int           m_wait;
    logic [31:0]  m_deliv;
    bit           m_etag, m_eunexp, m_eovf, m_eto;

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        m_tag.delete();
        exp_q.delete();
        m_out_cnt = 0;
        m_wait    = 0;
        m_deliv   = '0;
        m_etag    = 0;
        m_eunexp  = 0;
        m_eovf    = 0;
        m_eto     = 0;
    endtask

    task automatic check_state();
        check_eq("outstanding", outstanding, m_tag.size());
        check_eq("delivered_cnt", delivered_cnt, m_deliv);
        check_eq("rdback_valid", rdback_valid, m_out_cnt > 0);
        check_eq("err_tag_ovf", err_tag_ovf, m_etag);
        check_eq("err_unexp", err_unexp, m_eunexp);
        check_eq("err_out_ovf", err_out_ovf, m_eovf);
        check_eq("err_timeout", err_timeout, m_eto);
    endtask

    // Drive one cycle of stimulus, advance the model, then check after the edge.
    task automatic step(input bit issue, input bit maint, input bit pv,
                        input logic [511:0] data, input bit ready, input bit clr);
        bit empty0, tpop, opop, t;
        rd_issue       = issue;
        rd_issue_maint = maint;
        phy_rd_valid   = pv;
        phy_rd_data    = data;
        rdback_ready   = ready;
        clr_err        = clr;

        empty0 = (m_tag.size() == 0);
        tpop   = pv && !empty0;
        opop   = (m_out_cnt > 0) && ready;
        if (clr) begin
            m_etag = 0; m_eunexp = 0; m_eovf = 0; m_eto = 0;
        end
        if (pv && empty0) m_eunexp = 1;
        if (tpop) begin
            t = m_tag.pop_front();
            if (!t) begin
                if (m_out_cnt < int'(OUT_DEPTH) || opop) begin
                    exp_q.push_back(data);
                    m_out_cnt++;
                    m_deliv++;
                end else begin
                    m_eovf = 1;
                end
            end
        end
        if (issue) begin
            if (m_tag.size() < int'(TAG_DEPTH)) m_tag.push_back(maint);
            else m_etag = 1;
        end
        if (opop) m_out_cnt--;
        if (tpop || empty0) m_wait = 0;
        else if (m_wait < int'(TIMEOUT) + 1) m_wait++;
        if (m_wait == int'(TIMEOUT) + 1) m_eto = 1;

        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input int n, input bit ready);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, ready, 0);
    endtask

    // Scoreboard: the head must match the oldest expected burst whenever valid.
    always @(negedge clk) begin
        if (!rst && rdback_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("head_unexpected", rdback_valid, 1'b0);
            end else begin
                check_eq("head_data", rdback_data, exp_q[0]);
                if (rdback_ready) exp_q.delete(0);
            end
        end
    end

    initial begin
        logic [511:0] a, b, c;
        rst = 1'b1;
        rd_issue = 0; rd_issue_maint = 0; phy_rd_valid = 0; phy_rd_data = '0;
        rdback_ready = 0; clr_err = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_data", rdback_data, '0);
        check_state();
        rst = 1'b0;

        // Maint burst in the middle is discarded.
        step(1, 0, 0, '0, 1, 0);
        step(1, 1, 0, '0, 1, 0);
        step(1, 0, 0, '0, 1, 0);
        a = mk_data(); b = mk_data(); c = mk_data();
        step(0, 0, 1, a, 1, 0);
        step(0, 0, 1, b, 1, 0);
        step(0, 0, 1, c, 1, 0);
        idle(3, 1);
        check_eq("t1_delivered", delivered_cnt, 32'd2);

        // Output overflow with consumer stalled, then drain and clear.
        for (int i = 0; i < 9; i++) step(1, 0, 0, '0, 0, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, mk_data(), 0, 0);
        check_eq("t2_ovf", err_out_ovf, 1'b1);
        idle(3, 0);
        idle(9, 1);
        step(0, 0, 0, '0, 1, 1);
        check_eq("t2_clr", err_out_ovf, 1'b0);

        // Tag FIFO overflow, then full drain.
        for (int i = 0; i < 17; i++) step(1, 0, 0, '0, 1, 0);
        check_eq("t3_full", outstanding, 5'd16);
        check_eq("t3_ovf", err_tag_ovf, 1'b1);
        for (int i = 0; i < 16; i++) step(0, 0, 1, mk_data(), 1, 0);
        idle(2, 1);
        check_eq("t3_empty", outstanding, 5'd0);
        step(0, 0, 0, '0, 1, 1);

        // Unexpected data, alone and together with an issue.
        step(0, 0, 1, mk_data(), 1, 0);
        check_eq("t4_unexp", err_unexp, 1'b1);
        step(0, 0, 0, '0, 1, 1);
        step(1, 0, 1, mk_data(), 1, 0);
        check_eq("t4_same_unexp", err_unexp, 1'b1);
        check_eq("t4_same_out", outstanding, 5'd1);
        step(0, 0, 1, mk_data(), 1, 0);
        idle(2, 1);
        step(0, 0, 0, '0, 1, 1);

        // Timeout boundary: fires TIMEOUT+1 cycles after the issue.
        step(1, 0, 0, '0, 1, 0);
        idle(TIMEOUT, 1);
        check_eq("t5_before", err_timeout, 1'b0);
        idle(1, 1);
        check_eq("t5_fire", err_timeout, 1'b1);
        step(0, 0, 1, mk_data(), 1, 0);
        idle(2, 1);
        step(0, 0, 0, '0, 1, 1);
        step(1, 0, 0, '0, 1, 0);
        idle(TIMEOUT - 1, 1);
        step(0, 0, 1, mk_data(), 1, 0);
        idle(3, 1);
        check_eq("t5_no_timeout", err_timeout, 1'b0);

        // Back-to-back streaming with ready held high.
        step(1, 0, 0, '0, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 1, mk_data(), 1, 0);
        step(0, 0, 1, mk_data(), 1, 0);
        idle(2, 1);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0, mk_data(), $urandom_range(0, 2) != 0, 0);
        for (int i = 0; i < 32 && m_tag.size() > 0; i++) step(0, 0, 1, mk_data(), 1, 0);
        idle(10, 1);
        step(0, 0, 0, '0, 1, 1);

        // Reset mid-stream with 5 outstanding and 3 held.
        for (int i = 0; i < 8; i++) step(1, 0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, mk_data(), 0, 0);
        check_eq("t6_pre_out", outstanding, 5'd5);
        rd_issue = 0; phy_rd_valid = 0; rdback_ready = 0; clr_err = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("t6_rst_data", rdback_data, '0);
        check_state();
        #2;
        rst = 1'b0;
        step(1, 0, 0, '0, 1, 0);
        step(0, 0, 1, mk_data(), 1, 0);
        idle(3, 1);
        check_eq("t6_delivered", delivered_cnt, 32'd1);

        check_eq("exp_left", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
